// File: rtl/dual_grant_dispatcher_if.sv
// Handshake/grant bundle between the dual-priority encoder, the dispatcher
// and the two service-channel consumers.
interface dual_grant_dispatcher_if #(
  parameter int N_REQ   = 15,
  parameter int IDX_W   = 4,
  parameter int COUNT_W = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [IDX_W-1:0]   in_first;
  logic [IDX_W-1:0]   in_second;
  logic [N_REQ-1:0]   gnt_a;
  logic               gnt_a_valid;
  logic               gnt_a_ack;
  logic [N_REQ-1:0]   gnt_b;
  logic               gnt_b_valid;
  logic               gnt_b_ack;
  logic               to_a;
  logic               to_b;
  logic               busy;
  logic [COUNT_W-1:0] grant_count;

  // Dispatcher side
  modport slave (
    input  in_valid, in_first, in_second, gnt_a_ack, gnt_b_ack,
    output in_ready, gnt_a, gnt_a_valid, gnt_b, gnt_b_valid,
           to_a, to_b, busy, grant_count
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_first, in_second, gnt_a_ack, gnt_b_ack,
    input  in_ready, gnt_a, gnt_a_valid, gnt_b, gnt_b_valid,
           to_a, to_b, busy, grant_count
  );
endinterface

// File: rtl/dual_grant_dispatcher.sv
// Dual grant dispatcher: captures a (first, second) priority index pair and
// drives two independent one-hot grant channels, each held until ack or
// timeout. A new pair is accepted only once both channels have retired.

// One grant channel: holds a one-hot grant, retires on ack or timeout.
module dgd_channel #(
  parameter int N_REQ   = 15,
  parameter int IDX_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             ack_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             vld_o,
  output logic             vld_d_o,
  output logic             to_o,
  output logic             ack_ret_o
);
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             vld_q, vld_d;
  logic             to_q, to_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;

  // Load / hold / retire decision; ack takes priority over expiry.
  always_comb begin
    gnt_d     = gnt_q;
    vld_d     = vld_q;
    cnt_d     = cnt_q;
    to_d      = 1'b0;
    ack_ret_o = 1'b0;
    if (load_i) begin
      gnt_d = N_REQ'(1) << (idx_i - IDX_W'(1));
      vld_d = 1'b1;
      cnt_d = '0;
    end else if (vld_q) begin
      if (ack_i) begin
        ack_ret_o = 1'b1;
        vld_d     = 1'b0;
        gnt_d     = '0;
        cnt_d     = '0;
      end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
        to_d  = 1'b1;
        vld_d = 1'b0;
        gnt_d = '0;
        cnt_d = '0;
      end else if (TIMEOUT != 0) begin
        cnt_d = cnt_q + TO_W'(1);
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q <= '0;
      vld_q <= 1'b0;
      to_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      gnt_q <= gnt_d;
      vld_q <= vld_d;
      to_q  <= to_d;
      cnt_q <= cnt_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign vld_o   = vld_q;
  assign vld_d_o = vld_d;
  assign to_o    = to_q;
endmodule

module dual_grant_dispatcher #(
  parameter int N_REQ   = 15,
  parameter int IDX_W   = 4,
  parameter int TIMEOUT = 15,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  dual_grant_dispatcher_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e state_q, state_d;

  logic [1:0][IDX_W-1:0] idx;
  logic [1:0][N_REQ-1:0] gnt;
  logic [1:0]            load, ack, vld, vld_d, to, ack_ret;
  logic                  en_a, en_b, accept;
  logic [COUNT_W-1:0]    cnt_q, cnt_d;
  logic [COUNT_W:0]      sum;

  // B is only meaningful when it ranks strictly below A; anything else is
  // treated as "no second requester".
  assign en_a   = (bus.in_first != '0);
  assign en_b   = (bus.in_second != '0) && (bus.in_second < bus.in_first);
  assign accept = bus.in_valid && (state_q == IDLE);

  assign idx[0]  = bus.in_first;
  assign idx[1]  = bus.in_second;
  assign ack[0]  = bus.gnt_a_ack;
  assign ack[1]  = bus.gnt_b_ack;
  assign load[0] = accept && en_a;
  assign load[1] = accept && en_b;

  for (genvar c = 0; c < 2; c++) begin : g_ch
    dgd_channel #(.N_REQ(N_REQ), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (load[c]),
      .idx_i     (idx[c]),
      .ack_i     (ack[c]),
      .gnt_o     (gnt[c]),
      .vld_o     (vld[c]),
      .vld_d_o   (vld_d[c]),
      .to_o      (to[c]),
      .ack_ret_o (ack_ret[c])
    );
  end

  // Next state: enter GRANT on a useful pair, leave once both channels retire.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && (en_a || en_b)) state_d = GRANT;
      GRANT:   if (vld_d == 2'b00) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Saturating count of acknowledged grants (0, 1 or 2 per cycle).
  always_comb begin
    sum   = {1'b0, cnt_q} + {{COUNT_W{1'b0}}, ack_ret[0]} + {{COUNT_W{1'b0}}, ack_ret[1]};
    cnt_d = sum[COUNT_W] ? {COUNT_W{1'b1}} : sum[COUNT_W-1:0];
  end

  // FSM state and grant counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.busy        = (state_q == GRANT);
  assign bus.gnt_a       = gnt[0];
  assign bus.gnt_a_valid = vld[0];
  assign bus.to_a        = to[0];
  assign bus.gnt_b       = gnt[1];
  assign bus.gnt_b_valid = vld[1];
  assign bus.to_b        = to[1];
  assign bus.grant_count = cnt_q;
endmodule

// File: doc/dual_grant_dispatcher.md
Name: dual_grant_dispatcher

Overview:
- Sits directly downstream of the 15-bit dual-priority encoder.
- Captures a (first, second) index pair with a valid/ready handshake.
- Converts the pair into two one-hot grants on independent service channels A and B, and holds each grant until it is acknowledged or times out.
- Accepts a new pair only after both channels have retired.

Parameters:
N_REQ, 15, number of requesters; index i in 1..N_REQ maps to grant bit i-1
IDX_W, 4, index width; index 0 means "no request"
TIMEOUT, 15, max cycles a grant stays valid without ack; 0 disables timeout
COUNT_W, 16, width of grant_count

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  index pair valid
in_ready  output  1  block can accept a pair
in_first  input  IDX_W  highest-priority index, 0 = none
in_second  input  IDX_W  second-priority index, 0 = none
gnt_a  output  N_REQ  one-hot grant, channel A (from first)
gnt_a_valid  output  1  channel A grant valid
gnt_a_ack  input  1  channel A consumer accepts grant
gnt_b  output  N_REQ  one-hot grant, channel B (from second)
gnt_b_valid  output  1  channel B grant valid
gnt_b_ack  input  1  channel B consumer accepts grant
to_a  output  1  one-cycle pulse, channel A grant timed out
to_b  output  1  one-cycle pulse, channel B grant timed out
busy  output  1  high while in GRANT state
grant_count  output  COUNT_W  total acknowledged grants, saturating

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - All grants, valids, timeout pulses and internal counters cleared; grant_count = 0.
  - Asserting reset mid-GRANT drops outstanding grants immediately; no timeout pulse.
- FSM has two states: IDLE, GRANT.
- in_ready = (state == IDLE), combinational from state only.
- Acceptance in IDLE (in_valid & in_ready at edge T):
  - Channel A enabled iff in_first != 0.
  - Channel B enabled iff in_second != 0 and in_second < in_first. Any other in_second, including the protocol violation second >= first, suppresses B.
  - If neither channel is enabled: pair consumed and dropped; state stays IDLE; no outputs change.
  - Otherwise: state -> GRANT. gnt_x = 1 << (idx-1) and gnt_x_valid for each enabled channel are registered, visible in cycle T+1. Disabled channels hold gnt_x = 0, gnt_x_valid = 0. Timeout counters are zeroed.
- Grant holding: gnt_x and gnt_x_valid stay stable until retired. The consumer must not see a change while valid is high.
- Channel retire (per channel, independent):
  - gnt_x_ack sampled high while gnt_x_valid high -> valid and gnt cleared at that edge; grant_count credited.
  - Else, if TIMEOUT != 0 and the counter == TIMEOUT-1 -> valid and gnt cleared; to_x = 1 for exactly the next cycle. Valid is therefore high at most TIMEOUT cycles.
  - Ack and timeout expiry on the same edge: ack wins, no to_x pulse.
  - Otherwise the counter increments.
  - gnt_x_ack while gnt_x_valid is low is ignored.
- State return: when both valids are low after an edge (both retired, possibly on the same edge), state -> IDLE at that edge. in_ready is high the following cycle. Minimum pair-to-pair spacing is 2 cycles (accept, 1-cycle ack).
- grant_count:
  - Adds (a_ack_retire + b_ack_retire), i.e. 0, 1 or 2, per cycle.
  - Saturates at 2^COUNT_W-1; +2 from max-1 gives max.
  - Timeouts are not counted.
- busy = (state == GRANT), registered with state.
- to_a and to_b may pulse in the same cycle.

Test Plan:
1. Reset then pair first=15, second=9 accepted at T -> T+1: gnt_a=0x4000, gnt_b=0x0100, both valid, in_ready=0; acks together at T+3 -> valids low, state IDLE, in_ready=1 at T+4, grant_count=2.
2. first=5, second=0 -> only A valid, gnt_a=0x0010, gnt_b=0; ack at T+1 -> in_ready=1 at T+2, grant_count=1. Then first=0, second=0 -> consumed, stays IDLE, no valids.
3. TIMEOUT=15, first=3, second=1, A acked at T+2, B never acked -> gnt_b_valid high exactly 15 cycles; to_b pulses one cycle; to_a never pulses; grant_count=1; then IDLE.
4. B ack on the same edge its counter hits TIMEOUT-1 -> no to_b pulse, grant_count increments; malformed pair first=4, second=7 -> only A granted.
5. rst_n low mid-GRANT, asynchronous between edges -> all valids, grants, busy and grant_count drop to 0 immediately; in_ready=1 after release.
6. COUNT_W=2: preload to 3 via acks, then a double ack -> grant_count stays 3 (saturation); in_valid held high during GRANT -> no second capture until in_ready returns.
